// File: rtl/bram_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and one BRAM port.
// The slave modport is the arbiter's view; master is the environment's view.
interface bram_arbiter_if #(
    parameter int P_DATA_WIDTH    = 16,
    parameter int P_ADDRESS_WIDTH = 10
);
    logic                       I_REQ_0;
    logic                       I_REQ_1;
    logic                       I_WE_0;
    logic                       I_WE_1;
    logic [P_ADDRESS_WIDTH-1:0] I_ADDRESS_0;
    logic [P_ADDRESS_WIDTH-1:0] I_ADDRESS_1;
    logic [P_DATA_WIDTH-1:0]    I_DATA_0;
    logic [P_DATA_WIDTH-1:0]    I_DATA_1;
    logic                       O_GRANT_0;
    logic                       O_GRANT_1;
    logic                       O_RVALID_0;
    logic                       O_RVALID_1;
    logic [P_DATA_WIDTH-1:0]    O_RDATA;
    logic                       O_BUSY;
    logic [P_ADDRESS_WIDTH-1:0] O_BRAM_ADDRESS;
    logic [P_DATA_WIDTH-1:0]    O_BRAM_DATA;
    logic                       O_BRAM_WRITE_ENABLE;
    logic [P_DATA_WIDTH-1:0]    I_BRAM_DATA;

    modport slave (
        input  I_REQ_0, I_REQ_1, I_WE_0, I_WE_1,
        input  I_ADDRESS_0, I_ADDRESS_1, I_DATA_0, I_DATA_1,
        input  I_BRAM_DATA,
        output O_GRANT_0, O_GRANT_1, O_RVALID_0, O_RVALID_1,
        output O_RDATA, O_BUSY,
        output O_BRAM_ADDRESS, O_BRAM_DATA, O_BRAM_WRITE_ENABLE
    );

    modport master (
        output I_REQ_0, I_REQ_1, I_WE_0, I_WE_1,
        output I_ADDRESS_0, I_ADDRESS_1, I_DATA_0, I_DATA_1,
        output I_BRAM_DATA,
        input  O_GRANT_0, O_GRANT_1, O_RVALID_0, O_RVALID_1,
        input  O_RDATA, O_BUSY,
        input  O_BRAM_ADDRESS, O_BRAM_DATA, O_BRAM_WRITE_ENABLE
    );
endinterface

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one synchronous-read BRAM port between two requesters.
// All outputs come from registers; O_BUSY is decoded from the registered state.
module bram_arbiter #(
    parameter int P_DATA_WIDTH    = 16,
    parameter int P_ADDRESS_WIDTH = 10
) (
    input logic           I_CLK,
    input logic           I_NRESET,
    bram_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ACCESS    = 2'd1;
    localparam logic [1:0] READ_DATA = 2'd2;

    logic [1:0]                 state;
    logic                       last_grant;
    logic                       owner;
    logic                       owner_we;
    logic                       grant_0;
    logic                       grant_1;
    logic                       rvalid_0;
    logic                       rvalid_1;
    logic                       bram_we;
    logic [P_ADDRESS_WIDTH-1:0] bram_address;
    logic [P_DATA_WIDTH-1:0]    bram_data;
    logic [P_DATA_WIDTH-1:0]    rdata;

    logic                       any_req;
    logic                       pick_1;
    logic                       pick_we;
    logic [P_ADDRESS_WIDTH-1:0] pick_address;
    logic [P_DATA_WIDTH-1:0]    pick_data;

    always_comb begin
        any_req      = bus.I_REQ_0 | bus.I_REQ_1;
        // Requester 1 wins alone, or on a tie when requester 0 was granted last.
        pick_1       = bus.I_REQ_1 & (~bus.I_REQ_0 | ~last_grant);
        pick_we      = pick_1 ? bus.I_WE_1      : bus.I_WE_0;
        pick_address = pick_1 ? bus.I_ADDRESS_1 : bus.I_ADDRESS_0;
        pick_data    = pick_1 ? bus.I_DATA_1    : bus.I_DATA_0;
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            owner_we     <= 1'b0;
            grant_0      <= 1'b0;
            grant_1      <= 1'b0;
            rvalid_0     <= 1'b0;
            rvalid_1     <= 1'b0;
            bram_we      <= 1'b0;
            bram_address <= '0;
            bram_data    <= '0;
            rdata        <= '0;
        end else begin
            grant_0  <= 1'b0;
            grant_1  <= 1'b0;
            rvalid_0 <= 1'b0;
            rvalid_1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner        <= pick_1;
                        last_grant   <= pick_1;
                        owner_we     <= pick_we;
                        bram_we      <= pick_we;
                        bram_address <= pick_address;
                        bram_data    <= pick_data;
                        grant_0      <= ~pick_1;
                        grant_1      <= pick_1;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    bram_we <= 1'b0;
                    state   <= owner_we ? IDLE : READ_DATA;
                end
                READ_DATA: begin
                    // BRAM output is valid now; capture it so O_RDATA holds afterwards.
                    rdata    <= bus.I_BRAM_DATA;
                    rvalid_0 <= ~owner;
                    rvalid_1 <= owner;
                    state    <= IDLE;
                end
                default: begin
                    bram_we <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.O_GRANT_0           = grant_0;
    assign bus.O_GRANT_1           = grant_1;
    assign bus.O_RVALID_0          = rvalid_0;
    assign bus.O_RVALID_1          = rvalid_1;
    assign bus.O_RDATA             = rdata;
    assign bus.O_BUSY              = (state != IDLE);
    assign bus.O_BRAM_ADDRESS      = bram_address;
    assign bus.O_BRAM_DATA         = bram_data;
    assign bus.O_BRAM_WRITE_ENABLE = bram_we;
endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: BRAM model, queue-driven requesters, a transaction-level
// reference model compared every cycle, and directed scenarios with literal expectations.
module tb_bram_arbiter;
    localparam int DW = 16;
    localparam int AW = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bram_arbiter_if #(.P_DATA_WIDTH(DW), .P_ADDRESS_WIDTH(AW)) bus ();

    bram_arbiter #(.P_DATA_WIDTH(DW), .P_ADDRESS_WIDTH(AW)) dut (
        .I_CLK   (clk),
        .I_NRESET(rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // BRAM port: synchronous read, write on the same edge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.O_BRAM_WRITE_ENABLE === 1'b1) mem[bus.O_BRAM_ADDRESS] <= bus.O_BRAM_DATA;
        bus.I_BRAM_DATA <= mem[bus.O_BRAM_ADDRESS];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requester agents: hold the head request until its grant is seen.
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;
    req_t q0[$];
    req_t q1[$];
    bit manual0 = 1'b0;

    always @(negedge clk) begin
        if (bus.O_GRANT_0 === 1'b1 && q0.size() != 0) void'(q0.pop_front());
        if (bus.O_GRANT_1 === 1'b1 && q1.size() != 0) void'(q1.pop_front());
        if (q0.size() != 0) begin
            bus.I_REQ_0 = 1'b1; bus.I_WE_0 = q0[0].we;
            bus.I_ADDRESS_0 = q0[0].addr; bus.I_DATA_0 = q0[0].data;
        end else if (!manual0) begin
            bus.I_REQ_0 = 1'b0; bus.I_WE_0 = 1'b0;
        end
        if (q1.size() != 0) begin
            bus.I_REQ_1 = 1'b1; bus.I_WE_1 = q1[0].we;
            bus.I_ADDRESS_1 = q1[0].addr; bus.I_DATA_1 = q1[0].data;
        end else begin
            bus.I_REQ_1 = 1'b0; bus.I_WE_1 = 1'b0;
        end
    end

    // Reference model: one transaction at a time, described by the edge it was granted at.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            cyc     = 0;
    int            free_at = 0;
    int            g_cyc   = -100;
    int            rv_cyc  = -100;
    bit            last    = 1'b1;
    bit            g_who   = 1'b0;
    bit            g_we    = 1'b0;
    bit            rv_who  = 1'b0;
    logic [AW-1:0] g_addr  = '0;
    logic [DW-1:0] g_data  = '0;
    logic [DW-1:0] rv_val  = '0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;
    logic [DW-1:0] m_rdata = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_at = 0; g_cyc = -100; rv_cyc = -100; last = 1'b1;
            g_who = 1'b0; g_we = 1'b0; rv_who = 1'b0;
            m_addr = '0; m_data = '0; m_rdata = '0;
        end else begin
            cyc++;
            if (g_we && cyc == g_cyc + 1) ref_mem[g_addr] = g_data;
            if (cyc == rv_cyc) m_rdata = rv_val;
            if (cyc >= free_at && (bus.I_REQ_0 === 1'b1 || bus.I_REQ_1 === 1'b1)) begin
                if (bus.I_REQ_0 === 1'b1 && bus.I_REQ_1 === 1'b1) g_who = ~last;
                else g_who = (bus.I_REQ_1 === 1'b1);
                last   = g_who;
                g_cyc  = cyc;
                g_we   = g_who ? bus.I_WE_1 : bus.I_WE_0;
                g_addr = g_who ? bus.I_ADDRESS_1 : bus.I_ADDRESS_0;
                g_data = g_who ? bus.I_DATA_1 : bus.I_DATA_0;
                m_addr = g_addr;
                m_data = g_data;
                if (g_we) begin
                    free_at = cyc + 2;
                end else begin
                    free_at = cyc + 3;
                    rv_cyc  = cyc + 2;
                    rv_who  = g_who;
                    rv_val  = ref_mem[g_addr];
                end
            end
        end
    end

    // Per-cycle compare plus event logs for the directed scenarios.
    typedef struct {
        int            c;
        bit            who;
        logic [DW-1:0] data;
    } ev_t;
    ev_t glog[$];
    ev_t rlog[$];
    int  we_cnt = 0;

    always @(negedge clk) begin
        chk("grant_0",  bus.O_GRANT_0,  (cyc == g_cyc && !g_who));
        chk("grant_1",  bus.O_GRANT_1,  (cyc == g_cyc && g_who));
        chk("rvalid_0", bus.O_RVALID_0, (cyc == rv_cyc && !rv_who));
        chk("rvalid_1", bus.O_RVALID_1, (cyc == rv_cyc && rv_who));
        chk("busy",     bus.O_BUSY,     (cyc >= g_cyc && cyc <= free_at - 2));
        chk("bram_we",  bus.O_BRAM_WRITE_ENABLE, (cyc == g_cyc && g_we));
        chk("bram_addr", bus.O_BRAM_ADDRESS, m_addr);
        chk("bram_data", bus.O_BRAM_DATA, m_data);
        chk("rdata",    bus.O_RDATA,    m_rdata);
        if (bus.O_GRANT_0 === 1'b1) glog.push_back('{cyc, 1'b0, '0});
        if (bus.O_GRANT_1 === 1'b1) glog.push_back('{cyc, 1'b1, '0});
        if (bus.O_RVALID_0 === 1'b1) rlog.push_back('{cyc, 1'b0, bus.O_RDATA});
        if (bus.O_RVALID_1 === 1'b1) rlog.push_back('{cyc, 1'b1, bus.O_RDATA});
        if (bus.O_BRAM_WRITE_ENABLE === 1'b1) we_cnt++;
    end

    task automatic clear_logs();
        glog.delete();
        rlog.delete();
        we_cnt = 0;
    endtask

    task automatic wait_idle(input int max);
        int quiet = 0;
        int n     = 0;
        while (quiet < 3 && n < max) begin
            @(negedge clk);
            n++;
            if (q0.size() == 0 && q1.size() == 0 && bus.O_BUSY === 1'b0) quiet++;
            else quiet = 0;
        end
        chk("idle_timeout", quiet, 3);
    endtask

    task automatic wait_grant(input bit who, input int max);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < max) begin
            @(negedge clk);
            n++;
            seen = who ? (bus.O_GRANT_1 === 1'b1) : (bus.O_GRANT_0 === 1'b1);
        end
        chk("grant_timeout", seen, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.I_REQ_0 = 1'b0; bus.I_REQ_1 = 1'b0;
        bus.I_WE_0 = 1'b0; bus.I_WE_1 = 1'b0;
        bus.I_ADDRESS_0 = '0; bus.I_ADDRESS_1 = '0;
        bus.I_DATA_0 = '0; bus.I_DATA_1 = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = (i < 8) ? DW'(i + 1) : '0;
            ref_mem[i] = (i < 8) ? DW'(i + 1) : '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",  bus.O_BUSY, 1'b0);
        chk("rst_rdata", bus.O_RDATA, 16'h0000);
        chk("rst_addr",  bus.O_BRAM_ADDRESS, 10'h000);
        chk("rst_we",    bus.O_BRAM_WRITE_ENABLE, 1'b0);
        #2 rst_n = 1'b1;

        // Single read of address 3
        clear_logs();
        q0.push_back('{1'b0, 10'd3, 16'h0000});
        wait_idle(40);
        chk("t1_ngrant", glog.size(), 1);
        chk("t1_nrv",    rlog.size(), 1);
        if (glog.size() == 1 && rlog.size() == 1) begin
            chk("t1_who",     rlog[0].who, 1'b0);
            chk("t1_rdata",   rlog[0].data, 16'h0004);
            chk("t1_latency", rlog[0].c - glog[0].c, 2);
        end

        // Simultaneous reads right after reset: 0 first, then 1
        do_reset();
        clear_logs();
        q0.push_back('{1'b0, 10'd1, 16'h0000});
        q1.push_back('{1'b0, 10'd5, 16'h0000});
        wait_idle(60);
        chk("t2_ngrant", glog.size(), 2);
        chk("t2_nrv",    rlog.size(), 2);
        if (glog.size() == 2 && rlog.size() == 2) begin
            chk("t2_first",  glog[0].who, 1'b0);
            chk("t2_second", glog[1].who, 1'b1);
            chk("t2_gap",    glog[1].c - glog[0].c, 3);
            chk("t2_rd0",    rlog[0].data, 16'h0002);
            chk("t2_rd1",    rlog[1].data, 16'h0006);
        end

        // Continuous contention for 6 reads: strict alternation, one idle cycle between
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            q0.push_back('{1'b0, AW'(2 * i), 16'h0000});
            q1.push_back('{1'b0, AW'(2 * i + 1), 16'h0000});
        end
        wait_idle(100);
        chk("t3_ngrant", glog.size(), 6);
        chk("t3_nrv",    rlog.size(), 6);
        if (glog.size() == 6 && rlog.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("t3_order", glog[i].who, i % 2);
                chk("t3_rdata", rlog[i].data, DW'(i + 1));
                if (i > 0) chk("t3_spacing", glog[i].c - glog[i-1].c, 3);
            end
        end

        // Write 0xBEEF from requester 1, read it back from requester 0
        clear_logs();
        q1.push_back('{1'b1, 10'd7, 16'hBEEF});
        wait_idle(40);
        chk("t4_we_cycles", we_cnt, 1);
        chk("t4_no_rvalid", rlog.size(), 0);
        q0.push_back('{1'b0, 10'd7, 16'h0000});
        wait_idle(40);
        chk("t4_nrv", rlog.size(), 1);
        if (rlog.size() == 1) begin
            chk("t4_who",   rlog[0].who, 1'b0);
            chk("t4_rdata", rlog[0].data, 16'hBEEF);
        end

        // Reset during READ_DATA aborts the read; tie afterwards goes to requester 0
        clear_logs();
        q0.push_back('{1'b0, 10'd2, 16'h0000});
        wait_grant(1'b0, 20);
        @(negedge clk);
        chk("t5_busy_before", bus.O_BUSY, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy",   bus.O_BUSY, 1'b0);
        chk("t5_rv0",    bus.O_RVALID_0, 1'b0);
        chk("t5_rdata",  bus.O_RDATA, 16'h0000);
        chk("t5_addr",   bus.O_BRAM_ADDRESS, 10'h000);
        chk("t5_data",   bus.O_BRAM_DATA, 16'h0000);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        chk("t5_aborted_rv", rlog.size(), 0);
        clear_logs();
        q0.push_back('{1'b0, 10'd6, 16'h0000});
        q1.push_back('{1'b0, 10'd0, 16'h0000});
        wait_idle(60);
        chk("t5_ngrant", glog.size(), 2);
        chk("t5_nrv",    rlog.size(), 2);
        if (glog.size() == 2 && rlog.size() == 2) begin
            chk("t5_first", glog[0].who, 1'b0);
            chk("t5_rd0",   rlog[0].data, 16'h0007);
            chk("t5_rd1",   rlog[1].data, 16'h0001);
        end

        // One-cycle write request from 0 while requester 1's read is in flight
        clear_logs();
        manual0 = 1'b1;
        q1.push_back('{1'b0, 10'd4, 16'h0000});
        wait_grant(1'b1, 20);
        bus.I_REQ_0 = 1'b1; bus.I_WE_0 = 1'b1;
        bus.I_ADDRESS_0 = 10'd0; bus.I_DATA_0 = 16'hDEAD;
        @(negedge clk);
        bus.I_REQ_0 = 1'b0; bus.I_WE_0 = 1'b0;
        manual0 = 1'b0;
        wait_idle(40);
        chk("t6_ngrant", glog.size(), 1);
        chk("t6_we",     we_cnt, 0);
        chk("t6_mem0",   mem[0], 16'h0001);
        chk("t6_nrv",    rlog.size(), 1);
        if (rlog.size() == 1) begin
            chk("t6_who",   rlog[0].who, 1'b1);
            chk("t6_rdata", rlog[0].data, 16'h0005);
        end

        // Final BRAM contents
        chk("mem7_beef", mem[7], 16'hBEEF);
        for (int i = 0; i < 8; i++) chk("mem_final", mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
